// File: rtl/cmd_encoder_rr_pkg.sv
// cmd_encoder_rr_pkg: shared types and helpers for the round-robin
// UART reply encoder.
package cmd_encoder_rr_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_ADDR = 3'd2,
        ST_LEN  = 3'd3,
        ST_PAY  = 3'd4,
        ST_CSUM = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmd_encoder_rr_arbiter.sv
// cmd_encoder_rr_arbiter: combinational round-robin search; picks the
// first set request at or after ptr, wrapping modulo N.
module cmd_encoder_rr_arbiter #(
    parameter int N  = 25,
    parameter int IW = 5
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    // Walk from the farthest candidate back to ptr so the closest wins.
    always_comb begin
        int p;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        p         = 0;
        for (int i = N - 1; i >= 0; i--) begin
            p = int'(ptr) + i;
            if (p >= N) p = p - N;
            if (req[IW'(p)]) begin
                gnt_idx   = IW'(p);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_encoder_rr.sv
// cmd_encoder_rr: arbitrates N_SRC message sources round-robin and
// serialises each message as SOF, ADDR, LEN, payload, CSUM.
module cmd_encoder_rr
    import cmd_encoder_rr_pkg::*;
#(
    parameter int         N_SRC   = 25,
    parameter int         DATA_W  = 8,
    parameter logic [7:0] SOF     = SOF_BYTE,
    parameter bit         CSUM_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [N_SRC-1:0]        have_msg_bus,
    input  logic [DATA_W*N_SRC-1:0] data_bus,
    input  logic [8*N_SRC-1:0]      len_bus,
    output logic [N_SRC-1:0]        rdreq_bus,
    input  logic [N_SRC-1:0]        src_mask,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic [7:0]              grant_id
);

    localparam int IW = idx_w(N_SRC);

    state_t            state_q, state_d, tail_st;
    logic [IW-1:0]     ptr_q, gnt_q, gnt_idx;
    logic              gnt_valid;
    logic [7:0]        len_q, cnt_q;
    logic [DATA_W-1:0] csum_q, tx_data_q, load_byte;
    logic              tx_valid_q, busy_q;
    logic              can_load, load;
    logic [DATA_W-1:0] data_arr [N_SRC];
    logic [7:0]        len_arr  [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_slice
        assign data_arr[i] = data_bus[DATA_W*i +: DATA_W];
        assign len_arr[i]  = len_bus[8*i +: 8];
    end

    cmd_encoder_rr_arbiter #(
        .N  (N_SRC),
        .IW (IW)
    ) u_arb (
        .req       (have_msg_bus & src_mask),
        .ptr       (ptr_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Output register may take a new byte when empty or draining now.
    assign can_load = !tx_valid_q || tx_ready;
    assign tail_st  = CSUM_EN ? ST_CSUM : ST_DONE;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (gnt_valid) state_d = ST_SOF;
            ST_SOF:  if (can_load) state_d = ST_ADDR;
            ST_ADDR: if (can_load) state_d = ST_LEN;
            ST_LEN:
                if (can_load)
                    state_d = (len_q != 8'd0) ? ST_PAY : tail_st;
            ST_PAY:
                if (can_load && cnt_q == 8'd1) state_d = tail_st;
            ST_CSUM: if (can_load) state_d = ST_DONE;
            ST_DONE:
                if (tx_valid_q && tx_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        load_byte = '0;
        rdreq_bus = '0;
        unique case (state_q)
            ST_SOF: begin
                load      = can_load;
                load_byte = SOF;
            end
            ST_ADDR: begin
                load      = can_load;
                load_byte = DATA_W'(gnt_q);
            end
            ST_LEN: begin
                load      = can_load;
                load_byte = DATA_W'(len_q);
            end
            ST_PAY: begin
                load             = can_load;
                load_byte        = data_arr[gnt_q];
                rdreq_bus[gnt_q] = can_load;
            end
            ST_CSUM: begin
                load      = can_load;
                load_byte = csum_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && gnt_valid) begin
                gnt_q  <= gnt_idx;
                len_q  <= len_arr[gnt_idx];
                cnt_q  <= len_arr[gnt_idx];
                csum_q <= DATA_W'(gnt_idx) + DATA_W'(len_arr[gnt_idx]);
                ptr_q  <= (int'(gnt_idx) == N_SRC - 1) ?
                          '0 : gnt_idx + IW'(1);
                busy_q <= 1'b1;
            end
            if (load) begin
                tx_data_q  <= load_byte;
                tx_valid_q <= 1'b1;
            end else if (tx_ready) begin
                tx_valid_q <= 1'b0;
            end
            if (load && state_q == ST_PAY) begin
                cnt_q  <= cnt_q - 8'd1;
                csum_q <= csum_q + load_byte;
            end
            if (state_q == ST_DONE && tx_valid_q && tx_ready)
                busy_q <= 1'b0;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign grant_id = 8'(gnt_q);

endmodule

// File: tb/tb_cmd_encoder_rr.sv
// tb_cmd_encoder_rr: scoreboard bench; a frame-level RR model fills the
// expected queues, an independent monitor pops and compares.
module tb_cmd_encoder_rr;

    localparam int NS = 25;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [NS-1:0]   have_msg_bus;
    logic [8*NS-1:0] data_bus;
    logic [8*NS-1:0] len_bus;
    logic [NS-1:0]   rdreq_bus;
    logic [NS-1:0]   src_mask;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic [7:0]      grant_id;

    cmd_encoder_rr #(
        .N_SRC   (NS),
        .DATA_W  (8),
        .SOF     (8'hAA),
        .CSUM_EN (1'b1)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .have_msg_bus (have_msg_bus),
        .data_bus     (data_bus),
        .len_bus      (len_bus),
        .rdreq_bus    (rdreq_bus),
        .src_mask     (src_mask),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    // Source-side stimulus state and model-side message copies
    logic [7:0] src_len [NS][$];
    logic [7:0] src_b   [NS][$];
    logic [7:0] m_len   [NS][$];
    logic [7:0] m_b     [NS][$];
    logic [7:0] exp_q[$];
    int         exp_gnt[$];
    int         exp_len[$];
    logic [7:0] pay[$];
    logic [NS-1:0] mask_v = '1;
    bit         ready_rnd = 1'b0;
    int         mptr = 0;

    int checks = 0;
    int errors = 0;

    int cur_gnt = 0;
    int cur_len = 0;
    int frame_pops = 0;
    int frame_bytes = 0;
    bit busy_prev = 1'b0;
    bit stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    task automatic add_msg(input int s);
        src_len[s].push_back(8'(pay.size()));
        m_len[s].push_back(8'(pay.size()));
        foreach (pay[k]) begin
            src_b[s].push_back(pay[k]);
            m_b[s].push_back(pay[k]);
        end
    endtask

    task automatic emit(input int s);
        int len;
        int sum;
        logic [7:0] b;
        len = int'(m_len[s].pop_front());
        sum = s + len;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'(s));
        exp_q.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
            b = m_b[s].pop_front();
            exp_q.push_back(b);
            sum += int'(b);
        end
        exp_q.push_back(8'(sum % 256));
        exp_gnt.push_back(s);
        exp_len.push_back(len);
        mptr = (s + 1) % NS;
    endtask

    // Serve every pending eligible message in round-robin order
    task automatic plan();
        bit found;
        int s;
        do begin
            found = 1'b0;
            for (int k = 0; k < NS; k++) begin
                s = (mptr + k) % NS;
                if (!found && mask_v[s] && m_len[s].size() > 0) begin
                    found = 1'b1;
                    emit(s);
                end
            end
        end while (found);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || busy || tx_valid) && n < 3000) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= 3000) fail({nm, "_timeout"});
        else chk({nm, "_frames_left"}, exp_gnt.size(), 0);
    endtask

    task automatic flush_all();
        for (int i = 0; i < NS; i++) begin
            src_len[i].delete();
            src_b[i].delete();
            m_len[i].delete();
            m_b[i].delete();
        end
        exp_q.delete();
        exp_gnt.delete();
        exp_len.delete();
        mptr = 0;
    endtask

    // Source driver: presents show-ahead data and drives the link
    initial begin
        have_msg_bus = '0;
        data_bus     = '0;
        len_bus      = '0;
        src_mask     = '1;
        tx_ready     = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                have_msg_bus[i]  = src_len[i].size() > 0;
                len_bus[8*i+:8]  = (src_len[i].size() > 0) ?
                                   src_len[i][0] : 8'h00;
                data_bus[8*i+:8] = (src_b[i].size() > 0) ?
                                   src_b[i][0] : 8'h00;
            end
            src_mask = mask_v;
            tx_ready = ready_rnd ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Monitor: values sampled here are the ones used at the next posedge
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!n_rst) begin
                busy_prev   = 1'b0;
                stall_prev  = 1'b0;
                frame_bytes = 0;
                continue;
            end
            if (stall_prev) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, stall_data);
            end
            if (busy && !busy_prev) begin
                if (exp_gnt.size() == 0) begin
                    fail("unexpected_grant");
                end else begin
                    cur_gnt = exp_gnt.pop_front();
                    cur_len = exp_len.pop_front();
                    chk("grant_id", grant_id, cur_gnt);
                    if (src_len[cur_gnt].size() > 0)
                        void'(src_len[cur_gnt].pop_front());
                end
                frame_pops  = 0;
                frame_bytes = 0;
            end
            if (rdreq_bus != '0) begin
                chk("rdreq_onehot", rdreq_bus, NS'(1) << cur_gnt);
                frame_pops++;
                if (src_b[cur_gnt].size() > 0)
                    void'(src_b[cur_gnt].pop_front());
            end
            if (busy && frame_bytes > 0)
                chk("no_bubble", tx_valid, 1);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) fail("unexpected_byte");
                else chk("tx_byte", tx_data, exp_q.pop_front());
                frame_bytes++;
            end
            if (!busy && busy_prev)
                chk("rdreq_count", frame_pops, cur_len);
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            busy_prev  = busy;
        end
    end

    initial begin
        int n;
        bit got;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rdreq", rdreq_bus, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        @(negedge clk);
        #1 n_rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // Basic frame, back-to-back, grant-to-SOF latency
        pay = '{8'h11, 8'h22};
        add_msg(3);
        plan();
        @(negedge clk); #3;
        chk("lat_edge1", tx_valid, 0);
        @(negedge clk); #3;
        chk("lat_edge2", tx_valid, 0);
        @(negedge clk); #3;
        chk("lat_sof_valid", tx_valid, 1);
        wait_idle("basic");

        // Simultaneous requests after grant 3: 5 before 1
        pay = '{8'h01};
        add_msg(1);
        pay = '{8'h05, 8'h06};
        add_msg(5);
        plan();
        wait_idle("rr_order");

        // Stalls under random ready
        ready_rnd = 1'b1;
        pay.delete();
        repeat (4) pay.push_back(8'($urandom));
        add_msg(0);
        plan();
        wait_idle("stall");
        ready_rnd = 1'b0;

        // Zero length and checksum wrap
        pay.delete();
        add_msg(7);
        pay = '{8'hFF, 8'hFF};
        add_msg(16);
        plan();
        wait_idle("len0_wrap");

        // Masked source is not granted until unmasked
        mask_v[2] = 1'b0;
        pay = '{8'h5A};
        add_msg(2);
        repeat (6) @(negedge clk);
        #3;
        chk("masked_busy", busy, 0);
        chk("masked_valid", tx_valid, 0);
        mask_v[2] = 1'b1;
        plan();
        got = 1'b0;
        for (int k = 0; k < 2 && !got; k++) begin
            @(negedge clk);
            #3;
            got = busy;
        end
        chk("unmask_grant", got, 1);
        wait_idle("unmask");

        // Pointer wraps from 24 to 0
        pay = '{8'h24};
        add_msg(24);
        plan();
        wait_idle("grant24");
        pay = '{8'h30};
        add_msg(23);
        pay = '{8'h31};
        add_msg(0);
        plan();
        wait_idle("ptr_wrap");

        // Randomised bursts, repeats force a full-rotation wait
        for (int ph = 0; ph < 6; ph++) begin
            ready_rnd = 1'($urandom % 2);
            n = 1 + int'($urandom % 4);
            for (int j = 0; j < n; j++) begin
                pay.delete();
                repeat ($urandom % 7) pay.push_back(8'($urandom));
                add_msg(int'($urandom % NS));
            end
            plan();
            wait_idle("random");
        end
        ready_rnd = 1'b0;

        // Reset during the third payload byte
        pay.delete();
        repeat (5) pay.push_back(8'($urandom));
        frame_pops = 0;
        add_msg(10);
        plan();
        n = 0;
        while (frame_pops < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("reset_wait_timeout");
        n_rst = 1'b0;
        #1;
        chk("arst_tx_valid", tx_valid, 0);
        chk("arst_rdreq", rdreq_bus, 0);
        chk("arst_busy", busy, 0);
        flush_all();
        repeat (2) @(negedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        #1;
        pay = '{8'h20};
        add_msg(20);
        pay = '{8'h03, 8'h04};
        add_msg(3);
        plan();
        wait_idle("post_reset");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
